sc_fb_scheduler: RTL and testbench

Single-clock sequencer for the stochastic-computing filter bank. It owns the per-frame cycle counter and emits the bit-reversed (van der Corput) sequence for the shared RNG comparators. It also generates the 4-phase slot select that time-shares the cascaded filter engine, plus the per-level sample-load enables that replace derived gated clocks. It wraps a run of N frames in a start/busy/done handshake with abort.

---
 rtl/sc_fb_pkg.sv | 38 +++
 rtl/sc_frame_counter.sv | 43 ++++
 rtl/sc_fb_scheduler.sv | 137 +++++++++++++
 tb/tb_sc_fb_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_fb_pkg.sv
// -----------------------------------------------------------------------------
// sc_fb_pkg
// Shared definitions for the stochastic-computing filter-bank sequencer:
//   - state_t      : run-control state encoding (IDLE, RUN, FINISH)
//   - SC_N, SC_LEVELS, SC_FRAME_W : default precision / level count / frame width
//   - bit_reverse  : van der Corput ordering, also used by the RNG/VDC logic
// -----------------------------------------------------------------------------
package sc_fb_pkg;

  localparam int SC_N       = 12;
  localparam int SC_LEVELS  = 4;
  localparam int SC_FRAME_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Reverse the low 'width' bits of 'value' (result right-aligned, upper bits
  // zero). Bits are shifted out LSB-first and into the result from the right,
  // so value[0] ends up at result[width-1]. Intended for constant 'width'.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                               input int unsigned width);
    logic [31:0] v;
    logic [31:0] r;
    v = value;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) begin
        r = {r[30:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_frame_counter.sv
// -----------------------------------------------------------------------------
// sc_frame_counter
// N-bit in-frame cycle counter plus frame index.
//   clock, reset : system clock, synchronous active-high reset
//   clr          : synchronous clear of cnt and frame_idx (priority over en)
//   en           : advance cnt this cycle (wraps 2^N-1 -> 0)
//   idx_en       : allow frame_idx to advance when cnt wraps; held low on the
//                  final frame so the index keeps its last value afterwards
//   cnt          : current in-frame cycle
//   wrap         : cnt is at its terminal value (unqualified by en)
//   frame_idx    : 0-based frame number
// -----------------------------------------------------------------------------
module sc_frame_counter #(
  parameter int N       = sc_fb_pkg::SC_N,
  parameter int FRAME_W = sc_fb_pkg::SC_FRAME_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic               idx_en,
  output logic [N-1:0]       cnt,
  output logic               wrap,
  output logic [FRAME_W-1:0] frame_idx
);

  assign wrap = &cnt;

  // NOTE: registers are updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt       <= '0;
      frame_idx <= '0;
    end else if (en) begin
      cnt <= cnt + N'(1);
      if (wrap && idx_en) begin
        frame_idx <= frame_idx + FRAME_W'(1);
      end
    end
  end

endmodule

// File: rtl/sc_fb_scheduler.sv
// -----------------------------------------------------------------------------
// sc_fb_scheduler
// Frame sequencer for the stochastic-computing filter bank. Runs num_frames
// frames of 2^N cycles under a start/busy/done handshake with abort.
//   clock, reset : system clock, synchronous active-high reset
//   start        : run request, sampled only in IDLE
//   abort        : return to IDLE next cycle from any state, no done pulse
//   num_frames   : frame count, latched on an accepted start
//   busy         : high while running
//   done         : one-cycle pulse after a normally completed run
//   seq          : bit-reversed cycle counter for the shared RNG comparators
//   slot         : 4-phase engine time-share select (cnt[1:0])
//   acc_clr      : first cycle of each frame
//   frame_end    : last cycle of each frame
//   lvl_load     : per-level sample-load enables (level k every 2^k frames)
//   frame_idx    : current 0-based frame number
// All outputs decode registered state only.
// -----------------------------------------------------------------------------
module sc_fb_scheduler
  import sc_fb_pkg::*;
#(
  parameter int N       = SC_N,
  parameter int LEVELS  = SC_LEVELS,
  parameter int FRAME_W = SC_FRAME_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [FRAME_W-1:0] num_frames,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       seq,
  output logic [1:0]         slot,
  output logic               acc_clr,
  output logic               frame_end,
  output logic [LEVELS-1:0]  lvl_load,
  output logic [FRAME_W-1:0] frame_idx
);

  state_t             state;
  state_t             state_next;
  logic [FRAME_W-1:0] nf;
  logic [N-1:0]       cnt;
  logic               wrap;
  logic               run;
  logic               last_frame;
  logic               ctr_clr;
  logic               ctr_en;
  logic               accept;

  assign run        = (state == RUN);
  assign last_frame = (frame_idx == nf - FRAME_W'(1));
  assign accept     = (state == IDLE) && start && !abort;

  sc_frame_counter #(
    .N       (N),
    .FRAME_W (FRAME_W)
  ) u_frame_counter (
    .clock     (clock),
    .reset     (reset),
    .clr       (ctr_clr),
    .en        (ctr_en),
    .idx_en    (!last_frame),
    .cnt       (cnt),
    .wrap      (wrap),
    .frame_idx (frame_idx)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame count is captured only when a run is accepted; starts during a run
  // or in FINISH leave it untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      nf <= '0;
    end else if (accept) begin
      nf <= num_frames;
    end
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (num_frames != '0) ? RUN : FINISH;
        end
      end
      RUN: begin
        if (wrap && last_frame) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
    end
  end

  // Output decode and counter control. The counter is held clear outside RUN,
  // so each run starts at cnt=0/frame_idx=0 and frame_idx reads 0 in IDLE
  // while still showing the last frame during FINISH.
  always_comb begin
    busy      = run;
    done      = (state == FINISH);
    seq       = run ? N'(bit_reverse(32'(cnt), N)) : '0;
    slot      = run ? cnt[1:0] : 2'b00;
    acc_clr   = run && (cnt == '0);
    frame_end = run && wrap;
    ctr_en    = run;
    ctr_clr   = !run || abort;
  end

  // Level k loads at the end of every frame whose low k index bits are all
  // ones, i.e. once per 2^k frames.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    if (k == 0) begin : g_base
      assign lvl_load[k] = frame_end;
    end else begin : g_dec
      assign lvl_load[k] = frame_end && (&frame_idx[k-1:0]);
    end
  end

endmodule

// File: tb/tb_sc_fb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sc_fb_scheduler
// Directed bench for sc_fb_scheduler with N=4 (16-cycle frames), LEVELS=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_sc_fb_scheduler;

  localparam int N       = 4;
  localparam int LEVELS  = 4;
  localparam int FRAME_W = 16;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic               abort;
  logic [FRAME_W-1:0] num_frames;
  logic               busy;
  logic               done;
  logic [N-1:0]       seq;
  logic [1:0]         slot;
  logic               acc_clr;
  logic               frame_end;
  logic [LEVELS-1:0]  lvl_load;
  logic [FRAME_W-1:0] frame_idx;

  int vectors     = 0;
  int miscompares = 0;
  int lvl_cnt[LEVELS];
  int lvl3_frame;
  int done_seen;
  int busy_seen;

  sc_fb_scheduler #(
    .N       (N),
    .LEVELS  (LEVELS),
    .FRAME_W (FRAME_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .num_frames (num_frames),
    .busy       (busy),
    .done       (done),
    .seq        (seq),
    .slot       (slot),
    .acc_clr    (acc_clr),
    .frame_end  (frame_end),
    .lvl_load   (lvl_load),
    .frame_idx  (frame_idx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".done"},      32'(done),      32'd0);
    check({tag, ".seq"},       32'(seq),       32'd0);
    check({tag, ".slot"},      32'(slot),      32'd0);
    check({tag, ".acc_clr"},   32'(acc_clr),   32'd0);
    check({tag, ".frame_end"}, 32'(frame_end), 32'd0);
    check({tag, ".lvl_load"},  32'(lvl_load),  32'd0);
    check({tag, ".frame_idx"}, 32'(frame_idx), 32'd0);
  endtask

  // Start a run of nfr frames and check every cycle against a cycle model:
  // cycle c (1-based after the accepting edge) has cnt=(c-1)%16, frame=(c-1)/16.
  // With poke set, a second start (num_frames=5) is driven at cycle 20.
  task automatic run_check(input string tag, input int nfr, input bit poke);
    logic [3:0]         cv;
    logic [LEVELS-1:0]  exp_lvl;
    logic [FRAME_W-1:0] m;
    logic [FRAME_W-1:0] fv;
    int                 f;
    for (int k = 0; k < LEVELS; k++) lvl_cnt[k] = 0;
    lvl3_frame = -1;
    start      = 1'b1;
    num_frames = FRAME_W'(nfr);
    advance();
    start      = 1'b0;
    for (int c = 1; c <= nfr * 16; c++) begin
      cv = 4'((c - 1) % 16);
      f  = (c - 1) / 16;
      fv = FRAME_W'(f);
      if (poke && c == 20) begin
        start      = 1'b1;
        num_frames = 16'd5;
      end
      if (poke && c == 21) start = 1'b0;
      check({tag, ".busy"},      32'(busy),      32'd1);
      check({tag, ".done"},      32'(done),      32'd0);
      check({tag, ".acc_clr"},   32'(acc_clr),   32'(cv == 4'd0));
      check({tag, ".slot"},      32'(slot),      32'(cv[1:0]));
      check({tag, ".seq"},       32'(seq),       32'({cv[0], cv[1], cv[2], cv[3]}));
      check({tag, ".frame_end"}, 32'(frame_end), 32'(cv == 4'd15));
      check({tag, ".frame_idx"}, 32'(frame_idx), 32'(fv));
      if (cv == 4'd1) check({tag, ".seq_cnt1"}, 32'(seq), 32'(4'b1000));
      if (cv == 4'd6) check({tag, ".seq_cnt6"}, 32'(seq), 32'(4'b0110));
      for (int k = 0; k < LEVELS; k++) begin
        m          = FRAME_W'((1 << k) - 1);
        exp_lvl[k] = (cv == 4'd15) && ((fv & m) == m);
      end
      check({tag, ".lvl_load"}, 32'(lvl_load), 32'(exp_lvl));
      for (int k = 0; k < LEVELS; k++) if (lvl_load[k]) lvl_cnt[k]++;
      if (lvl_load[3]) lvl3_frame = int'(frame_idx);
      advance();
    end
    check({tag, ".done_pulse"}, 32'(done),      32'd1);
    check({tag, ".done_busy"},  32'(busy),      32'd0);
    check({tag, ".done_idx"},   32'(frame_idx), 32'(nfr - 1));
    check({tag, ".done_seq"},   32'(seq),       32'd0);
    advance();
    check_quiet({tag, ".after"});
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    num_frames = '0;

    // Reset state
    advance();
    advance();
    check_quiet("reset");
    reset = 1'b0;
    advance();
    check_quiet("idle");

    // Three-frame run with a stray start at cycle 20 (must not disturb it)
    run_check("nf3", 3, 1'b1);

    // Eight-frame run: level-load pulse counts
    run_check("nf8", 8, 1'b0);
    check("lvl0_count",  32'(lvl_cnt[0]), 32'd8);
    check("lvl1_count",  32'(lvl_cnt[1]), 32'd4);
    check("lvl2_count",  32'(lvl_cnt[2]), 32'd2);
    check("lvl3_count",  32'(lvl_cnt[3]), 32'd1);
    check("lvl3_frame",  32'(lvl3_frame), 32'd7);

    // num_frames==0, start held high through FINISH
    start      = 1'b1;
    num_frames = 16'd0;
    advance();
    check("nf0.done1", 32'(done), 32'd1);
    check("nf0.busy1", 32'(busy), 32'd0);
    advance();
    check("nf0.done2", 32'(done), 32'd0);
    check("nf0.busy2", 32'(busy), 32'd0);
    advance();
    check("nf0.done3", 32'(done), 32'd1);
    check("nf0.busy3", 32'(busy), 32'd0);
    start = 1'b0;
    advance();
    check_quiet("nf0.after");

    // Abort at cycle 10 of frame 1 (cycle 27 after start)
    start      = 1'b1;
    num_frames = 16'd3;
    advance();
    start = 1'b0;
    for (int c = 1; c < 27; c++) advance();
    check("abort.pre_idx", 32'(frame_idx), 32'd1);
    check("abort.pre_seq", 32'(seq),       32'(4'b0101));
    check("abort.pre_slot", 32'(slot),     32'd2);
    abort = 1'b1;
    advance();
    abort = 1'b0;
    check_quiet("abort.next");
    done_seen = 0;
    busy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) done_seen++;
      if (busy) busy_seen++;
      advance();
    end
    check("abort.no_done", 32'(done_seen), 32'd0);
    check("abort.no_busy", 32'(busy_seen), 32'd0);

    // start and abort together in IDLE: abort wins
    start      = 1'b1;
    abort      = 1'b1;
    num_frames = 16'd3;
    advance();
    start = 1'b0;
    abort = 1'b0;
    check_quiet("start_abort");
    advance();
    check_quiet("start_abort2");

    // Reset asserted at cycle 20 of a run
    start      = 1'b1;
    num_frames = 16'd3;
    advance();
    start = 1'b0;
    for (int c = 1; c < 20; c++) advance();
    check("rst_mid.busy", 32'(busy), 32'd1);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    check_quiet("rst_mid");

    // Normal run after reset release
    run_check("nf1", 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
